// File: rtl/tri_setup.sv
// tri_setup: triangle setup buffer between the scene/transform stage and the
// rasterizer. Face records arrive on a one-cycle write strobe, are queued in a
// DEPTH-entry FIFO and are presented one at a time on a valid/ready handshake,
// together with a screen-clamped bounding box.
//
// Optional feature: define TRI_SETUP_CULL_EN to discard faces whose bounding box
// lies entirely off screen (counted in cull_count). Without it, every face is
// presented and cull_count is tied to zero.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   write_data[65:0], wen      face record {x0,y0,x1,y1,x2,y2,color} and strobe
//   full, overflow             FIFO full, sticky write-while-full flag
//   tri_valid, tri_ready       output handshake
//   tri_data[65:0]             presented face record
//   xmin, xmax, ymin, ymax     clamped bounding box of tri_data
//   tri_count, cull_count      16-bit wrapping handoff / cull counters
module tri_setup #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [65:0] write_data,
    input  logic        wen,
    output logic        full,
    output logic        overflow,
    output logic        tri_valid,
    input  logic        tri_ready,
    output logic [65:0] tri_data,
    output logic [9:0]  xmin,
    output logic [9:0]  xmax,
    output logic [9:0]  ymin,
    output logic [9:0]  ymax,
    output logic [15:0] tri_count,
    output logic [15:0] cull_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [9:0]  XLIM    = 10'(SCREEN_W - 1);
    localparam logic [9:0]  YLIM    = 10'(SCREEN_H - 1);

    typedef enum logic {S_EMPTY, S_HOLD} state_t;

    state_t        state;
    logic [65:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   occ;

    logic        fifo_empty;
    logic        do_write;
    logic        pop;
    logic        load;
    logic        cull_pop;
    logic [65:0] head;
    logic [9:0]  raw_xmin, raw_xmax, raw_ymin, raw_ymax;
    logic [9:0]  c_xmin, c_xmax, c_ymin, c_ymax;

    function automatic logic [9:0] min3(input logic [9:0] a, input logic [9:0] b,
                                        input logic [9:0] c);
        logic [9:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [9:0] max3(input logic [9:0] a, input logic [9:0] b,
                                        input logic [9:0] c);
        logic [9:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    assign fifo_empty = (occ == '0);
    assign full       = (occ == DEPTH_L);
    assign do_write   = wen && !full;
    // The output register can take the head when it is empty or is being
    // handed off this cycle.
    assign pop        = !fifo_empty && ((state == S_EMPTY) || tri_ready);
    assign head       = mem[rptr];

    always_comb begin
        raw_xmin = min3(head[65:56], head[45:36], head[25:16]);
        raw_xmax = max3(head[65:56], head[45:36], head[25:16]);
        raw_ymin = min3(head[55:46], head[35:26], head[15:6]);
        raw_ymax = max3(head[55:46], head[35:26], head[15:6]);
        c_xmin   = (raw_xmin > XLIM) ? XLIM : raw_xmin;
        c_xmax   = (raw_xmax > XLIM) ? XLIM : raw_xmax;
        c_ymin   = (raw_ymin > YLIM) ? YLIM : raw_ymin;
        c_ymax   = (raw_ymax > YLIM) ? YLIM : raw_ymax;
    end

`ifdef TRI_SETUP_CULL_EN
    logic head_off;
    // Offscreen test uses the unclamped minima.
    assign head_off = ({1'b0, raw_xmin} >= 11'(SCREEN_W)) ||
                      ({1'b0, raw_ymin} >= 11'(SCREEN_H));
    assign cull_pop = pop && head_off;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cull_count <= '0;
        end else if (cull_pop) begin
            cull_count <= cull_count + 16'd1;
        end
    end
`else
    assign cull_pop   = 1'b0;
    assign cull_count = '0;
`endif

    assign load = pop && !cull_pop;

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wptr] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            occ      <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_write) wptr <= wptr + AW'(1);
            if (pop)      rptr <= rptr + AW'(1);
            case ({do_write, pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
            // A write while full is dropped even if a pop frees a slot this edge.
            if (wen && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_EMPTY;
            tri_valid <= 1'b0;
            tri_data  <= '0;
            xmin      <= '0;
            xmax      <= '0;
            ymin      <= '0;
            ymax      <= '0;
            tri_count <= '0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (load) begin
                        state     <= S_HOLD;
                        tri_valid <= 1'b1;
                        tri_data  <= head;
                        xmin      <= c_xmin;
                        xmax      <= c_xmax;
                        ymin      <= c_ymin;
                        ymax      <= c_ymax;
                    end
                end
                S_HOLD: begin
                    if (tri_ready) begin
                        tri_count <= tri_count + 16'd1;
                        if (load) begin
                            tri_data <= head;
                            xmin     <= c_xmin;
                            xmax     <= c_xmax;
                            ymin     <= c_ymin;
                            ymax     <= c_ymax;
                        end else begin
                            state     <= S_EMPTY;
                            tri_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= S_EMPTY;
                    tri_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tri_setup.sv
module tb_tri_setup;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [65:0] write_data = '0;
    logic        wen = 1'b0;
    logic        full, overflow, tri_valid;
    logic        tri_ready = 1'b0;
    logic [65:0] tri_data;
    logic [9:0]  xmin, xmax, ymin, ymax;
    logic [15:0] tri_count, cull_count;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference: queued faces, the held face and counters.
    logic [65:0] m_q[$];
    bit          m_valid;
    logic [65:0] m_data;
    bit          m_ovf;
    logic [15:0] m_tc, m_cc;
    int          m_hs;

    tri_setup #(.DEPTH(16), .SCREEN_W(640), .SCREEN_H(480)) dut (
        .clk(clk), .reset(reset), .write_data(write_data), .wen(wen),
        .full(full), .overflow(overflow), .tri_valid(tri_valid),
        .tri_ready(tri_ready), .tri_data(tri_data),
        .xmin(xmin), .xmax(xmax), .ymin(ymin), .ymax(ymax),
        .tri_count(tri_count), .cull_count(cull_count)
    );

    always #5 clk = ~clk;

    function automatic logic [65:0] mk_face(input int x0, input int y0, input int x1,
                                            input int y1, input int x2, input int y2,
                                            input int col);
        return {10'(x0), 10'(y0), 10'(x1), 10'(y1), 10'(x2), 10'(y2), 6'(col)};
    endfunction

    function automatic logic [65:0] rand_face(input bit onscreen);
        int xs[3], ys[3];
        for (int i = 0; i < 3; i++) begin
            xs[i] = onscreen ? int'($urandom_range(0, 639)) : int'($urandom_range(0, 1023));
            ys[i] = onscreen ? int'($urandom_range(0, 479)) : int'($urandom_range(0, 1023));
        end
        return mk_face(xs[0], ys[0], xs[1], ys[1], xs[2], ys[2], int'($urandom_range(0, 63)));
    endfunction

    // {xmin, xmax, ymin, ymax}, clamped to the screen
    function automatic logic [39:0] exp_bbox(input logic [65:0] f);
        int xs[3], ys[3];
        int xn, xx, yn, yx;
        xs[0] = int'(f[65:56]); xs[1] = int'(f[45:36]); xs[2] = int'(f[25:16]);
        ys[0] = int'(f[55:46]); ys[1] = int'(f[35:26]); ys[2] = int'(f[15:6]);
        xn = 1 << 20; yn = 1 << 20; xx = -1; yx = -1;
        for (int i = 0; i < 3; i++) begin
            if (xs[i] < xn) xn = xs[i];
            if (xs[i] > xx) xx = xs[i];
            if (ys[i] < yn) yn = ys[i];
            if (ys[i] > yx) yx = ys[i];
        end
        if (xn > 639) xn = 639;
        if (xx > 639) xx = 639;
        if (yn > 479) yn = 479;
        if (yx > 479) yx = 479;
        return {10'(xn), 10'(xx), 10'(yn), 10'(yx)};
    endfunction

    function automatic bit is_offscreen(input logic [65:0] f);
        int xs[3], ys[3];
        xs[0] = int'(f[65:56]); xs[1] = int'(f[45:36]); xs[2] = int'(f[25:16]);
        ys[0] = int'(f[55:46]); ys[1] = int'(f[35:26]); ys[2] = int'(f[15:6]);
        return (xs[0] >= 640 && xs[1] >= 640 && xs[2] >= 640) ||
               (ys[0] >= 480 && ys[1] >= 480 && ys[2] >= 480);
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_valid = 0; m_data = '0; m_ovf = 0;
        m_tc = '0; m_cc = '0; m_hs = 0;
    endtask

    task automatic model_edge(input bit w, input logic [65:0] d, input bit r);
        bit was_full;
        logic [65:0] f;
        was_full = (m_q.size() == DEPTH);
        if (w && was_full) m_ovf = 1;
        if (m_valid && r) begin
            m_tc++; m_hs++; m_valid = 0;
        end
        if (!m_valid && m_q.size() > 0) begin
            f = m_q.pop_front();
`ifdef TRI_SETUP_CULL_EN
            if (is_offscreen(f)) m_cc++;
            else begin m_valid = 1; m_data = f; end
`else
            m_valid = 1; m_data = f;
`endif
        end
        if (w && !was_full) m_q.push_back(d);
    endtask

    // Drive from a negedge, advance one rising edge, return at the next negedge.
    task automatic step(input bit w, input logic [65:0] d, input bit r);
        wen = w; write_data = d; tri_ready = r;
        @(posedge clk);
        model_edge(w, d, r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        wen = 1'b0; tri_ready = 1'b0; write_data = '0;
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({full, overflow, tri_valid} !== 3'b000 || tri_data !== '0 ||
            {xmin, xmax, ymin, ymax} !== '0 || tri_count !== '0 || cull_count !== '0) begin
            errors++;
            $display("FAIL reset_state got f=%b o=%b v=%b d=%h bb=%h tc=%0d cc=%0d exp all zero",
                     full, overflow, tri_valid, tri_data, {xmin, xmax, ymin, ymax}, tri_count, cull_count);
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_single();
        logic [65:0] f;
        f = mk_face(0, 0, 50, 50, 50, 0, 63);
        step(1, f, 0);
        checks++;
        if (tri_valid !== 1'b0) begin
            errors++; $display("FAIL single_latency1 tri_valid got %b exp 0", tri_valid);
        end
        step(0, '0, 0);
        checks++;
        if (tri_valid !== 1'b1 || tri_data !== f) begin
            errors++; $display("FAIL single_present got v=%b d=%h exp v=1 d=%h", tri_valid, tri_data, f);
        end
        checks++;
        if ({xmin, xmax, ymin, ymax} !== {10'd0, 10'd50, 10'd0, 10'd50}) begin
            errors++; $display("FAIL single_bbox got %0d %0d %0d %0d exp 0 50 0 50", xmin, xmax, ymin, ymax);
        end
        step(0, '0, 1);
        checks++;
        if (tri_count !== 16'd1 || tri_valid !== 1'b0) begin
            errors++; $display("FAIL single_handoff got tc=%0d v=%b exp tc=1 v=0", tri_count, tri_valid);
        end
    endtask

    task automatic test_back_to_back();
        int vcycles;
        logic [15:0] tc0;
        do_reset();
        tc0 = tri_count;
        vcycles = 0;
        for (int i = 0; i < 16; i++) begin
            step(i < 12, rand_face(1), 1);
            if (tri_valid) vcycles++;
            checks++;
            if (tri_valid !== m_valid || (m_valid && tri_data !== m_data) || full !== 1'b0 ||
                overflow !== 1'b0) begin
                errors++;
                $display("FAIL b2b_cycle %0d got v=%b d=%h f=%b o=%b exp v=%b d=%h f=0 o=0",
                         i, tri_valid, tri_data, full, overflow, m_valid, m_data);
            end
        end
        checks++;
        if (vcycles != 12 || tri_count - tc0 !== 16'd12) begin
            errors++; $display("FAIL b2b_total got valid_cycles=%0d handoffs=%0d exp 12 12",
                               vcycles, tri_count - tc0);
        end
    endtask

    task automatic test_overflow();
        int n;
        do_reset();
        for (int k = 1; k <= 18; k++) begin
            step(1, rand_face(1), 0);
            checks++;
            if (full !== (k >= 17) || overflow !== (k >= 18)) begin
                errors++; $display("FAIL ovf_fill write %0d got f=%b o=%b exp f=%b o=%b",
                                   k, full, overflow, k >= 17, k >= 18);
            end
        end
        n = 0;
        while (m_valid && n < 40) begin
            step(0, '0, 1);
            n++;
            checks++;
            if (tri_valid !== m_valid || (m_valid && tri_data !== m_data)) begin
                errors++; $display("FAIL ovf_drain cycle %0d got v=%b d=%h exp v=%b d=%h",
                                   n, tri_valid, tri_data, m_valid, m_data);
            end
        end
        checks++;
        if (tri_count !== 16'd17 || overflow !== 1'b1 || full !== 1'b0 || tri_valid !== 1'b0) begin
            errors++; $display("FAIL ovf_total got tc=%0d o=%b f=%b v=%b exp tc=17 o=1 f=0 v=0",
                               tri_count, overflow, full, tri_valid);
        end
    endtask

    task automatic test_clamp();
        logic [65:0] f;
        do_reset();
        f = mk_face(700, 10, 100, 200, 300, 400, 5);
        step(1, f, 0);
        step(0, '0, 0);
        checks++;
        if (tri_valid !== 1'b1 || {xmin, xmax, ymin, ymax} !== {10'd100, 10'd639, 10'd10, 10'd400}) begin
            errors++; $display("FAIL clamp_xmax got v=%b bb=%0d %0d %0d %0d exp v=1 bb=100 639 10 400",
                               tri_valid, xmin, xmax, ymin, ymax);
        end
        step(0, '0, 1);
        f = mk_face(640, 20, 700, 30, 1000, 40, 9);
        step(1, f, 0);
        step(0, '0, 0);
        step(0, '0, 0);
`ifdef TRI_SETUP_CULL_EN
        checks++;
        if (tri_valid !== 1'b0 || cull_count !== 16'd1) begin
            errors++; $display("FAIL cull_offscreen got v=%b cc=%0d exp v=0 cc=1", tri_valid, cull_count);
        end
`else
        checks++;
        if (tri_valid !== 1'b1 || tri_data !== f || xmin !== 10'd639 || xmax !== 10'd639 ||
            cull_count !== 16'd0) begin
            errors++; $display("FAIL offscreen_present got v=%b xmin=%0d xmax=%0d cc=%0d exp v=1 639 639 cc=0",
                               tri_valid, xmin, xmax, cull_count);
        end
`endif
    endtask

    task automatic test_random();
        logic [39:0] bb;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1) == 1, rand_face($urandom_range(0, 3) != 0),
                 $urandom_range(0, 2) != 0);
            bb = exp_bbox(m_data);
            checks++;
            if (tri_valid !== m_valid || full !== (m_q.size() == DEPTH) || overflow !== m_ovf ||
                tri_count !== m_tc || cull_count !== m_cc ||
                (m_valid && (tri_data !== m_data || {xmin, xmax, ymin, ymax} !== bb))) begin
                errors++;
                $display("FAIL random cycle %0d got v=%b f=%b o=%b tc=%0d cc=%0d d=%h bb=%h exp v=%b f=%b o=%b tc=%0d cc=%0d d=%h bb=%h",
                         i, tri_valid, full, overflow, tri_count, cull_count, tri_data,
                         {xmin, xmax, ymin, ymax}, m_valid, m_q.size() == DEPTH, m_ovf, m_tc,
                         m_cc, m_data, bb);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [65:0] g;
        do_reset();
        for (int i = 0; i < 6; i++) step(1, rand_face(1), 0);
        checks++;
        if (tri_valid !== 1'b1 || m_q.size() != 5) begin
            errors++; $display("FAIL areset_setup got v=%b exp v=1 (model queue %0d exp 5)",
                               tri_valid, m_q.size());
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({full, overflow, tri_valid} !== 3'b000 || tri_data !== '0 ||
            {xmin, xmax, ymin, ymax} !== '0 || tri_count !== '0 || cull_count !== '0) begin
            errors++; $display("FAIL areset_async got f=%b o=%b v=%b d=%h tc=%0d exp all zero",
                               full, overflow, tri_valid, tri_data, tri_count);
        end
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        g = rand_face(1);
        step(1, g, 0);
        checks++;
        if (tri_valid !== 1'b0) begin
            errors++; $display("FAIL areset_fresh1 got v=%b exp 0", tri_valid);
        end
        step(0, '0, 0);
        checks++;
        if (tri_valid !== 1'b1 || tri_data !== g) begin
            errors++; $display("FAIL areset_fresh2 got v=%b d=%h exp v=1 d=%h", tri_valid, tri_data, g);
        end
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        for (int i = 0; i < 65537; i++) step(1, rand_face(1), 1);
        n = 0;
        while (m_hs < 65537 && n < 100) begin
            step(0, '0, 1);
            n++;
        end
        checks++;
        if (m_hs != 65537 || tri_count !== 16'd1 || tri_count !== m_tc || overflow !== 1'b0) begin
            errors++; $display("FAIL wrap got tc=%0d o=%b exp tc=1 o=0 (handoffs %0d)",
                               tri_count, overflow, m_hs);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_clamp();
        test_random();
        test_async_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tri_setup.md
# tri_setup

Triangle setup buffer sitting directly downstream of the scene/transform stage: it accepts packed screen-space face records on a write strobe, queues them in a FIFO, and presents them one at a time to the rasterizer over a valid/ready handshake. Each presented face also carries a screen-clamped bounding box. It decouples the bursty one-face-per-cycle producer from a rasterizer that stalls for many cycles per triangle.

## Interface
- DEPTH, 16, FIFO entries; power of two, 2..256
- SCREEN_W, 640, horizontal pixel count; x coordinates 0..SCREEN_W-1 are on screen
- SCREEN_H, 480, vertical pixel count; y coordinates 0..SCREEN_H-1 are on screen
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- write_data  input  66  face record: [65:56] x0, [55:46] y0, [45:36] x1, [35:26] y1, [25:16] x2, [15:6] y2, [5:0] color; coordinates unsigned
- wen  input  1  one-cycle strobe; write_data is valid in the same cycle
- full  output  1  FIFO holds DEPTH entries
- overflow  output  1  sticky; set when wen arrives while full
- tri_valid  output  1  output register holds a face
- tri_ready  input  1  rasterizer accepts the face this cycle
- tri_data  output  66  presented face record, unmodified
- xmin, xmax, ymin, ymax  output  10 each  clamped bounding box of tri_data
- tri_count  output  16  faces handed off (tri_valid and tri_ready)
- cull_count  output  16  faces discarded by culling

## Operation
- FIFO: DEPTH×66 storage; read and write pointers of log2(DEPTH) bits wrap naturally; an occupancy counter of log2(DEPTH)+1 bits drives full.
- Write: on a wen edge with full low, write_data is stored and occupancy increments. On a wen edge with full high, the record is dropped and overflow is set, even if a pop occurs on the same edge. overflow clears only on reset.
- Output stage FSM, two states:
  - EMPTY: tri_valid=0. If the FIFO is non-empty, pop the head into the output register and go to HOLD.
  - HOLD: tri_valid=1; tri_data and the bbox stay stable until handshake. On tri_valid&&tri_ready, tri_count increments and the state reloads directly from the FIFO if it is non-empty (HOLD, no bubble); otherwise it goes to EMPTY.
- Simultaneous wen and pop with the FIFO non-full: both occur and occupancy is unchanged. A write into an empty FIFO is not bypassed; it becomes poppable on the next edge.
- Bounding box: computed combinationally from the FIFO head and registered with the record. xmin=min(x0,x1,x2), xmax=max(...), and likewise for y. Each value is then clamped to SCREEN_W-1 (x) or SCREEN_H-1 (y). Unsigned compares only.
- Offscreen test, applied before clamping: raw xmin ≥ SCREEN_W or raw ymin ≥ SCREEN_H.
- Counters are 16 bits and wrap from 0xFFFF to 0.

## Timing
- Reset values: full=0, overflow=0, tri_valid=0, tri_data=0, xmin=xmax=ymin=ymax=0, tri_count=0, cull_count=0; FSM in EMPTY; FIFO empty.
- Latency with an idle pipeline: a record written at edge E has tri_valid high after edge E+1.
- Throughput: one face per cycle while tri_ready is held high and the FIFO is non-empty.
- full asserts after the edge that writes the DEPTHth entry. It deasserts after the first pop that leaves occupancy below DEPTH.
- An asserted reset mid-burst empties the FIFO and drops the held face immediately, without waiting for a clock. The rasterizer sees tri_valid fall asynchronously.
- tri_ready is ignored while tri_valid=0.

## Configuration
- TRI_SETUP_CULL_EN defined: when the head face is offscreen, it is popped but not loaded into the output register, and cull_count increments. The discard takes one cycle per face and the FSM stays in or returns to EMPTY. Culling also applies on the reload-from-HOLD path, in which case the FSM goes to EMPTY.
- TRI_SETUP_CULL_EN undefined: every face is presented, including fully offscreen ones, with their bbox clamped. cull_count is tied to 0.

## Test plan
- Reset then a single wen with x/y = (0,0),(50,50),(50,0), color 0x3F -> tri_valid high after the 2nd edge; xmin=0, xmax=50, ymin=0, ymax=50; tri_data equals the input; with tri_ready=1, tri_count=1.
- 12 consecutive wen cycles with tri_ready=1 -> 12 faces emitted in order, back-to-back with no bubbles after the first; full never asserts; overflow=0.
- tri_ready=0 and 18 writes with DEPTH=16 -> 1 face held in the output register and 16 in the FIFO; full=1 from the 17th write; the 18th is dropped; overflow=1. Then release tri_ready -> exactly 17 faces emitted.
- Vertex x=700 with the others <640 -> xmax=639, xmin unchanged. All x ≥ 640 -> with TRI_SETUP_CULL_EN, face never presented and cull_count=1; without it, presented with xmin=xmax=639.
- Assert reset while tri_valid=1 and the FIFO holds 5 faces -> all outputs at reset values with no clock edge; a fresh write afterwards appears after 2 edges.
- Hold tri_ready high for 65537 handshakes -> tri_count reads 1 (wrap).
